// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared types, width formulas and saturation helper for the
//               folded symmetric FIR.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package fir_pkg;

  localparam int c_SAT_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACUM = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of distinct coefficients in a symmetric filter of n taps.
  function automatic int calc_m(input int n);
    return (n + 1) / 2;
  endfunction

  function automatic int calc_acc_w(input int data_w, input int coef_w, input int n);
    return data_w + 1 + coef_w + clog2(calc_m(n));
  endfunction

  // Clamp v to the signed range of a w-bit number.
  function automatic logic signed [c_SAT_W-1:0] saturate(
    input logic signed [c_SAT_W-1:0] v,
    input int                        w
  );
    logic signed [c_SAT_W-1:0] hi;
    logic signed [c_SAT_W-1:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_simetrico_param_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_simetrico_param_if
// Description : Sample-in / sample-out handshake bundle of the FIR.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface fir_simetrico_param_if #(
  parameter int DATA_W = 20
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_sat;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/mac_simetrico.sv
`default_nettype none
// ============================================================================
// Module      : mac_simetrico
// Description : Pre-adder, signed multiplier and clearable accumulator.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module mac_simetrico #(
  parameter int DATA_W = 20,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 40
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     clr,
  input  wire logic                     en,
  input  wire logic                     single,
  input  wire logic signed [DATA_W-1:0] x_a,
  input  wire logic signed [DATA_W-1:0] x_b,
  input  wire logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]       acc
);
  localparam int c_PROD_W = DATA_W + 1 + COEF_W;

  logic signed [DATA_W:0]     w_a;
  logic signed [DATA_W:0]     w_b;
  logic signed [DATA_W:0]     w_pre;
  logic signed [c_PROD_W-1:0] w_pre_x;
  logic signed [c_PROD_W-1:0] w_coef_x;
  logic signed [c_PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;

  // The middle tap of an odd-length filter has no mirror partner.
  always_comb begin
    w_a      = {x_a[DATA_W-1], x_a};
    w_b      = {x_b[DATA_W-1], x_b};
    w_pre    = single ? w_a : (w_a + w_b);
    w_pre_x  = c_PROD_W'(w_pre);
    w_coef_x = c_PROD_W'(coef);
    w_prod   = w_pre_x * w_coef_x;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign acc = r_acc;
endmodule
`default_nettype wire

// File: rtl/fir_simetrico_param.sv
`default_nettype none
// ============================================================================
// Module      : fir_simetrico_param
// Description : Folded symmetric FIR with handshake, writable coefficients,
//               rounding, saturation and latency-matched bypass.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fir_simetrico_param
  import fir_pkg::*;
#(
  parameter int DATA_W    = 20,
  parameter int COEF_W    = 16,
  parameter int N_TAPS    = 16,
  parameter int OUT_SHIFT = 15,
  localparam int c_M      = calc_m(N_TAPS),
  localparam int c_ADDR_W = (c_M > 1) ? clog2(c_M) : 1
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  fir_simetrico_param_if.slave          bus,
  input  wire logic                     bypass,
  input  wire logic                     coef_we,
  input  wire logic [c_ADDR_W-1:0]      coef_addr,
  input  wire logic signed [COEF_W-1:0] coef_data,
  output logic                          busy
);
  localparam int c_ACC_W  = calc_acc_w(DATA_W, COEF_W, N_TAPS);
  localparam int c_XIDX_W = clog2(N_TAPS);

  fir_state_t                r_state;
  logic signed [DATA_W-1:0]  r_x [N_TAPS];
  logic signed [COEF_W-1:0]  r_h [c_M];
  logic [c_ADDR_W-1:0]       r_k;
  logic                      r_bypass;
  logic signed [DATA_W-1:0]  r_out_data;
  logic                      r_out_valid;
  logic                      r_out_sat;

  logic                      w_accept;
  logic                      w_single;
  logic [c_XIDX_W-1:0]       w_ia;
  logic [c_XIDX_W-1:0]       w_ib;
  logic signed [c_ACC_W-1:0] w_acc;
  logic signed [c_ACC_W:0]   w_acc_x;
  logic signed [c_ACC_W:0]   w_round;
  logic signed [c_SAT_W-1:0] w_wide;
  logic signed [c_SAT_W-1:0] w_sat;
  logic                      w_clip;

  assign bus.in_ready = (r_state == ST_IDLE) && !coef_we;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign busy         = (r_state != ST_IDLE);

  assign w_ia     = c_XIDX_W'(r_k);
  assign w_ib     = c_XIDX_W'(N_TAPS - 1) - w_ia;
  assign w_single = ((N_TAPS % 2) == 1) && (int'(r_k) == c_M - 1);

  mac_simetrico #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (c_ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_accept),
    .en     (r_state == ST_ACUM),
    .single (w_single),
    .x_a    (r_x[w_ia]),
    .x_b    (r_x[w_ib]),
    .coef   (r_h[r_k]),
    .acc    (w_acc)
  );

  // One guard bit keeps the rounding offset from wrapping the accumulator.
  assign w_acc_x = {w_acc[c_ACC_W-1], w_acc};

  generate
    if (OUT_SHIFT > 0) begin : g_round
      localparam logic signed [c_ACC_W:0] c_HALF = (c_ACC_W + 1)'(1) <<< (OUT_SHIFT - 1);
      assign w_round = (w_acc_x + c_HALF) >>> OUT_SHIFT;
    end else begin : g_no_round
      assign w_round = w_acc_x;
    end
  endgenerate

  assign w_wide = c_SAT_W'(w_round);
  assign w_sat  = saturate(w_wide, DATA_W);
  assign w_clip = (w_sat != w_wide);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_bypass    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) r_x[i] <= '0;
      for (int i = 0; i < c_M; i++) r_h[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (coef_we && (int'(coef_addr) < c_M)) r_h[coef_addr] <= coef_data;
          if (w_accept) begin
            r_x[0] <= bus.in_data;
            for (int i = 1; i < N_TAPS; i++) r_x[i] <= r_x[i-1];
            r_bypass <= bypass;
            r_k      <= '0;
            r_state  <= ST_ACUM;
          end
        end
        ST_ACUM: begin
          if (int'(r_k) == c_M - 1) r_state <= ST_OUT;
          else                      r_k     <= r_k + c_ADDR_W'(1);
        end
        ST_OUT: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b1;
          if (r_bypass) begin
            r_out_data <= r_x[0];
            r_out_sat  <= 1'b0;
          end else begin
            r_out_data <= DATA_W'(w_sat);
            r_out_sat  <= w_clip;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sat   = r_out_sat;
endmodule
`default_nettype wire

// File: doc/fir_simetrico_param.md
Name: fir_simetrico_param

Overview:
- Parametrised successor of the fixed 20-bit symmetric FIR audio filter.
- Folded symmetric FIR: pre-adds mirrored delay-line taps, then uses one time-shared multiplier-accumulator.
- A valid/ready sample handshake replaces the fixed sampling-clock divider.
- Adds a run-time writable coefficient bank, rounding, saturation with overflow flag, and a latency-matched bypass mode.
- Sits between the audio sample source and the output stage, all in one clock domain.

Parameters:
- DATA_W, 20: signed sample width, in and out.
- COEF_W, 16: signed coefficient width.
- N_TAPS, 16: filter length; even or odd, >= 2.
- OUT_SHIFT, 15: right shift applied to the accumulator before saturation; 0 allowed.

Ports:
- clk, in, 1: single system clock; rising edge.
- reset, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: in_data holds a sample.
- in_ready, out, 1: block can accept a sample.
- in_data, in, DATA_W: signed input sample.
- out_valid, out, 1: one-cycle pulse; out_data is new.
- out_data, out, DATA_W: signed filtered sample.
- out_sat, out, 1: saturation occurred; valid with out_valid.
- bypass, in, 1: pass the sample through instead of filtering.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, clog2(M): coefficient index, M = ceil(N_TAPS/2).
- coef_data, in, COEF_W: signed coefficient value.
- busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous), all cleared immediately:
  - delay line, accumulator, coefficients: 0.
  - out_data = 0, out_valid = 0, out_sat = 0.
  - FSM state: IDLE.
- A reset asserted mid-computation aborts it; no out_valid is produced for the aborted sample.
- Widths: M = ceil(N_TAPS/2); ACC_W = DATA_W + 1 + COEF_W + clog2(M). All arithmetic is signed.
- FSM states IDLE -> ACUM -> OUT -> IDLE.
- IDLE:
  - in_ready = !coef_we.
  - Accept when in_valid && in_ready: delay line shifts with x[0] = in_data (x[0] newest); bypass is latched; acc = 0; k = 0; go to ACUM.
- ACUM, lasts exactly M cycles, k = 0..M-1:
  - each cycle acc += (x[k] + x[N_TAPS-1-k]) * h[k]; the pre-add is DATA_W+1 bits.
  - For odd N_TAPS, at k = M-1 the middle tap uses x[k] alone (not doubled).
- OUT, 1 cycle:
  - if OUT_SHIFT > 0, r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up); otherwise r = acc.
  - r is saturated to the signed DATA_W range; out_sat = 1 if clipped.
  - If latched bypass = 1: r = x[0] and out_sat = 0.
  - Output registers are updated on the OUT->IDLE edge.
- Latency and throughput:
  - Sample accepted at edge E0 gives out_valid high for one cycle after edge E(M+1).
  - in_ready is high again in that same cycle; throughput is one sample per M+2 cycles.
- out_data holds its value between out_valid pulses.
- in_valid while busy: held off (in_ready = 0); the sample must stay stable until accepted, and no data is lost.
- Coefficient writes:
  - take effect at the clock edge only when the FSM is IDLE and coef_addr < M;
  - otherwise they are silently ignored.
- coef_we with in_valid in IDLE: the write wins and the sample waits one cycle.
- busy = (state != IDLE).

Decomposition:
- Shared package fir_pkg holds:
  - the clog2 function;
  - state encodings IDLE/ACUM/OUT;
  - the ACC_W and M localparam formulas;
  - a saturation helper function.
- One sub-module, mac_simetrico: pre-adder, multiplier and accumulator with a clear input; ACC_W-wide result. The FSM, delay line, coefficient bank and output stage stay in the top.

Test Plan:
- N_TAPS=4, OUT_SHIFT=0, h0=1, h1=2; impulse 100 followed by zeros -> outputs 100, 200, 200, 100, 0; each out_valid 3 cycles after acceptance.
- N_TAPS=3, OUT_SHIFT=0, h0=1, h1=5; impulse 10 -> 10, 50, 10; middle tap not doubled.
- Defaults, h[all]=32767; constant input 524287 -> out_data = 524287 with out_sat = 1. Same setup with -524288 -> -524288, out_sat = 1.
- OUT_SHIFT=15, h0=16384, others 0; x=3 -> (3*16384 + 16384) >>> 15 = 2, out_sat = 0.
- bypass=1, in_data=-1234 -> out_data = -1234 with out_valid after the same M+2 cycles; coef_we while busy=1 -> coefficient unchanged (verify with a later impulse).
- reset pulsed low mid-ACUM -> outputs 0 immediately, no out_valid, in_ready=1 on release; next impulse output equals all-zero-coefficient response 0.
